time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/clock_pkg.sv | 42 ++++
 rtl/bcd_counter.sv | 32 +++
 rtl/time_keeper.sv | 94 +++++++++
 tb/tb_time_keeper.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and encodings for the time keeper and the display path.
package clock_pkg;

  // Operating modes: free-running clock, then one set mode per field.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_t;

  // blink_sel encodings: which field the display blanks during blink.
  localparam logic [1:0] SEL_HH   = 2'b00;
  localparam logic [1:0] SEL_MM   = 2'b01;
  localparam logic [1:0] SEL_SS   = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // Two BCD digits, {tens, units}.
  typedef logic [7:0] bcd8_t;

  // Binary constant to BCD, used for elaboration-time limits only.
  function automatic bcd8_t to_bcd8(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Add one to a legal BCD pair; units 9 rolls into tens.
  function automatic bcd8_t bcd8_inc(input bcd8_t v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Field selection presented for each mode.
  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      SET_HH:  return SEL_HH;
      SET_MM:  return SEL_MM;
      SET_SS:  return SEL_SS;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Two-digit BCD counter 00..MAX with a combinational wrap carry.
module bcd_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  clr,
  output bcd8_t value,
  output logic  carry
);

  localparam bcd8_t MAX_BCD = to_bcd8(MAX);

  // carry is asserted in the same cycle as the inc that wraps, so a chain
  // of counters rolls over together on one edge.
  assign carry = inc && (value == MAX_BCD);

  // Count register: clear wins over increment; MAX wraps to 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 8'h00;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      value <= (value == MAX_BCD) ? 8'h00 : bcd8_inc(value);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// HH:MM:SS time-of-day keeper with button-driven set modes and blink control.
// Button semantics: btn_mode advances RUN->SET_HH->SET_MM->SET_SS->RUN;
// btn_inc bumps the field being set and is dropped if btn_mode is also high.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned HOURS_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       blink_en,
  output logic [1:0] blink_sel
);

  state_t state, state_next;
  logic   phase, phase_next;
  logic   inc_ok;
  logic   ss_inc, mm_inc, hh_inc;
  logic   ss_carry, mm_carry, hh_carry_unused;

  // Mode change has priority over a simultaneous increment.
  assign inc_ok = btn_inc && !btn_mode;

  // Counting only in RUN; set-mode increments touch one field, no carry.
  assign ss_inc = ((state == RUN) && tick_1hz) || ((state == SET_SS) && inc_ok);
  assign mm_inc = ((state == RUN) && ss_carry) || ((state == SET_MM) && inc_ok);
  assign hh_inc = ((state == RUN) && mm_carry) || ((state == SET_HH) && inc_ok);

  bcd_counter #(.MAX(59)) u_ss (
    .clk   (clk),
    .rst   (rst),
    .inc   (ss_inc),
    .clr   (1'b0),
    .value (ss),
    .carry (ss_carry)
  );

  bcd_counter #(.MAX(59)) u_mm (
    .clk   (clk),
    .rst   (rst),
    .inc   (mm_inc),
    .clr   (1'b0),
    .value (mm),
    .carry (mm_carry)
  );

  bcd_counter #(.MAX(HOURS_MAX)) u_hh (
    .clk   (clk),
    .rst   (rst),
    .inc   (hh_inc),
    .clr   (1'b0),
    .value (hh),
    .carry (hh_carry_unused)
  );

  // Next mode and next blink phase; phase restarts at 0 on any mode change.
  always_comb begin
    state_next = state;
    phase_next = phase;
    if (btn_mode) begin
      case (state)
        RUN:     state_next = SET_HH;
        SET_HH:  state_next = SET_MM;
        SET_MM:  state_next = SET_SS;
        default: state_next = RUN;
      endcase
    end
    if (state_next != state) phase_next = 1'b0;
    else if (tick_2hz)       phase_next = ~phase;
  end

  // Mode, phase and blink outputs registered together so they never skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      phase     <= 1'b0;
      blink_en  <= 1'b0;
      blink_sel <= SEL_NONE;
    end else begin
      state     <= state_next;
      phase     <= phase_next;
      blink_en  <= (state_next != RUN) && phase_next;
      blink_sel <= sel_of(state_next);
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: two instances (24h and 12h wrap) driven in lockstep,
// checked cycle by cycle against a seconds-of-day reference model.
module tb_time_keeper;

  localparam int OBS_W = 27;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz, tick_2hz, btn_mode, btn_inc;
  logic [7:0] hh24, mm24, ss24, hh12, mm12, ss12;
  logic       be24, be12;
  logic [1:0] bs24, bs12;

  int n_tests = 0;
  int n_fail  = 0;

  logic [OBS_W-1:0] exp_q24[$];
  logic [OBS_W-1:0] exp_q12[$];

  // Reference model: shared mode/phase, per-instance time as integers.
  int  m_mode;
  bit  m_phase;
  int  m_h[2], m_m[2], m_s[2];
  int  hmax[2] = '{23, 11};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  time_keeper u_dut24 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hh(hh24), .mm(mm24), .ss(ss24), .blink_en(be24), .blink_sel(bs24)
  );

  time_keeper #(.HOURS_MAX(11)) u_dut12 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hh(hh12), .mm(mm12), .ss(ss12), .blink_en(be12), .blink_sel(bs12)
  );

  // ---------------- model ----------------
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [OBS_W-1:0] model_obs(input int k);
    logic       be;
    logic [1:0] bs;
    be = (m_mode != 0) && m_phase;
    bs = (m_mode == 0) ? 2'b11 : 2'(m_mode - 1);
    return {to_bcd(m_h[k]), to_bcd(m_m[k]), to_bcd(m_s[k]), be, bs};
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_phase = 0;
    for (int k = 0; k < 2; k++) begin
      m_h[k] = 0; m_m[k] = 0; m_s[k] = 0;
    end
  endtask

  task automatic model_apply(input bit t1, input bit t2, input bit md, input bit inc);
    int tot;
    for (int k = 0; k < 2; k++) begin
      if (m_mode == 0 && t1) begin
        tot = ((m_h[k] * 60 + m_m[k]) * 60 + m_s[k] + 1) % ((hmax[k] + 1) * 3600);
        m_h[k] = tot / 3600;
        m_m[k] = (tot / 60) % 60;
        m_s[k] = tot % 60;
      end
      if (!md && inc) begin
        if (m_mode == 1) m_h[k] = (m_h[k] + 1) % (hmax[k] + 1);
        if (m_mode == 2) m_m[k] = (m_m[k] + 1) % 60;
        if (m_mode == 3) m_s[k] = (m_s[k] + 1) % 60;
      end
    end
    if (md) begin
      m_mode  = (m_mode + 1) % 4;
      m_phase = 0;
    end else if (t2) begin
      m_phase = !m_phase;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit t1, input bit t2, input bit md, input bit inc);
    @(negedge clk);
    tick_1hz = t1;
    tick_2hz = t2;
    btn_mode = md;
    btn_inc  = inc;
    model_apply(t1, t2, md, inc);
    exp_q24.push_back(model_obs(0));
    exp_q12.push_back(model_obs(1));
  endtask

  task automatic idle_inputs();
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic check_reset(input string name);
    n_tests++;
    if ({hh24, mm24, ss24, be24, bs24} !== {24'h000000, 1'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL %s_h23 act=%h_%h_%h be=%b sel=%b exp=00_00_00 be=0 sel=11",
               name, hh24, mm24, ss24, be24, bs24);
    end
    n_tests++;
    if ({hh12, mm12, ss12, be12, bs12} !== {24'h000000, 1'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL %s_h11 act=%h_%h_%h be=%b sel=%b exp=00_00_00 be=0 sel=11",
               name, hh12, mm12, ss12, be12, bs12);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [OBS_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q24.size() > 0) begin
        e = exp_q24.pop_front();
        n_tests++;
        if ({hh24, mm24, ss24, be24, bs24} !== e) begin
          n_fail++;
          $display("FAIL scoreboard_h23 t=%0t act=%h exp=%h", $time,
                   {hh24, mm24, ss24, be24, bs24}, e);
        end
      end
      if (exp_q12.size() > 0) begin
        e = exp_q12.pop_front();
        n_tests++;
        if ({hh12, mm12, ss12, be12, bs12} !== e) begin
          n_fail++;
          $display("FAIL scoreboard_h11 t=%0t act=%h exp=%h", $time,
                   {hh12, mm12, ss12, be12, bs12}, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    check_reset("reset_initial");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 60 seconds in RUN -> 00:01:00
    for (int i = 0; i < 60; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // SET_HH: 25 increments wrap the hour; tick_1hz is frozen out
    step(0, 0, 1, 0);
    for (int i = 0; i < 25; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // SET_MM: walk to 59, wrap without touching hh, then mode+inc together
    step(0, 0, 1, 0);
    while (m_m[0] != 59) step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);

    // SET_SS: blink phase sequence, then back to RUN
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Preload 23:59:59 (11:59:59 on the 12h instance) and roll over
    step(0, 0, 1, 0);
    while (m_h[0] != 23) step(0, $urandom_range(0, 1), 0, 1);
    step(0, 0, 1, 0);
    while (m_m[0] != 59) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    while (m_s[0] != 59) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Async reset in the middle of SET_MM
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    @(posedge clk);
    #3;
    idle_inputs();
    rst = 1'b1;
    #1;
    check_reset("reset_async_set_mm");
    repeat (2) @(posedge clk);
    exp_q24.delete();
    exp_q12.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q24.size() != 0 || exp_q12.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain act=%0d/%0d exp=0/0", exp_q24.size(), exp_q12.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
